// File: rtl/vga_pkg.sv
// Shared VGA constants: colour format, default transparent key and the frame
// geometry used to size per-frame pixel counters.
package vga_pkg;

  localparam int COLOR_W = 12;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;

  localparam logic [11:0] DEFAULT_KEY_COLOR = WHITE;

  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int FRAME_PIXELS    = H_ACTIVE * V_ACTIVE;
  localparam int COLLISION_CNT_W = $clog2(FRAME_PIXELS + 1);

endpackage

// File: rtl/layer_compositor_priority_select.sv
// Combinational priority picker: the highest-index opaque layer wins, otherwise
// the background colour is passed through.
module priority_select #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12
) (
  input  logic [NUM_LAYERS-1:0]         opaque,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layers,
  input  logic [COLOR_W-1:0]            bg,
  output logic [COLOR_W-1:0]            sel_color,
  output logic                          any_opaque
);

  // Scanning upward lets later (higher-priority) layers overwrite earlier ones.
  always_comb begin
    sel_color  = bg;
    any_opaque = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (opaque[i]) begin
        sel_color  = layers[i*COLOR_W +: COLOR_W];
        any_opaque = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor with frame-synchronous shadowed configuration and
// a per-frame overlap pixel counter.
module layer_compositor #(
  parameter int                 NUM_LAYERS       = 4,
  parameter int                 COLOR_W          = vga_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR        = vga_pkg::DEFAULT_KEY_COLOR,
  parameter int                 CNT_W            = vga_pkg::COLLISION_CNT_W,
  parameter bit                 VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                          ClkPort,
  input  logic                          Reset,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic [COLOR_W-1:0]            bg_color,
  input  logic                          hSync_in,
  input  logic                          vSync_in,
  input  logic                          bright_in,
  output logic                          hSync_out,
  output logic                          vSync_out,
  output logic                          bright_out,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic [CNT_W-1:0]              collision_count,
  output logic                          collision_flag,
  output logic                          frame_done
);

  import vga_pkg::*;

  localparam logic             SYNC_IDLE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic                          vsync_prev_q, vsync_prev_d;
  logic [NUM_LAYERS-1:0]         shadow_en_q, shadow_en_d;
  logic [COLOR_W-1:0]            shadow_bg_q, shadow_bg_d;
  logic [CNT_W-1:0]              acc_q, acc_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          flag_q, flag_d;
  logic                          done_q, done_d;

  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb_q, s1_rgb_d;
  logic [NUM_LAYERS-1:0]         s1_opaque_q, s1_opaque_d;
  logic [COLOR_W-1:0]            s1_bg_q, s1_bg_d;
  logic                          s1_hsync_q, s1_hsync_d;
  logic                          s1_vsync_q, s1_vsync_d;
  logic                          s1_bright_q, s1_bright_d;

  logic [COLOR_W-1:0]            rgb_q, rgb_d;
  logic                          hsync_q, hsync_d;
  logic                          vsync_q, vsync_d;
  logic                          bright_q, bright_d;

  logic                          vsync_act, vsync_prev_act, frame_start;
  logic [NUM_LAYERS-1:0]         opaque;
  logic                          seen_one, multi_opaque, overlap;
  logic [CNT_W-1:0]              acc_next;
  logic [COLOR_W-1:0]            sel_color;
  logic                          any_opaque;

  priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W)
  ) u_priority_select (
    .opaque     (s1_opaque_q),
    .layers     (s1_rgb_q),
    .bg         (s1_bg_q),
    .sel_color  (sel_color),
    .any_opaque (any_opaque)
  );

  // Frame start is the assertion edge of vSync against its registered copy.
  always_comb begin
    vsync_act      = VSYNC_ACTIVE_LOW ? ~vSync_in : vSync_in;
    vsync_prev_act = VSYNC_ACTIVE_LOW ? ~vsync_prev_q : vsync_prev_q;
    frame_start    = vsync_act & ~vsync_prev_act;
    vsync_prev_d   = vSync_in;
  end

  always_comb begin
    opaque       = '0;
    seen_one     = 1'b0;
    multi_opaque = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = (layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR) & shadow_en_q[i];
      if (opaque[i]) begin
        if (seen_one) multi_opaque = 1'b1;
        seen_one = 1'b1;
      end
    end
    overlap = bright_in & multi_opaque;
  end

  // The frame-start pixel's own overlap is folded into the published count.
  always_comb begin
    acc_next    = (overlap && (acc_q != CNT_MAX)) ? acc_q + CNT_W'(1) : acc_q;
    acc_d       = frame_start ? '0 : acc_next;
    count_d     = frame_start ? acc_next : count_q;
    flag_d      = frame_start ? (acc_next != '0) : flag_q;
    done_d      = frame_start;
    shadow_en_d = frame_start ? layer_en : shadow_en_q;
    shadow_bg_d = frame_start ? bg_color : shadow_bg_q;
  end

  always_comb begin
    s1_rgb_d    = layer_rgb;
    s1_opaque_d = opaque;
    s1_bg_d     = shadow_bg_q;
    s1_hsync_d  = hSync_in;
    s1_vsync_d  = vSync_in;
    s1_bright_d = bright_in;

    hsync_d  = s1_hsync_q;
    vsync_d  = s1_vsync_q;
    bright_d = s1_bright_q;
    if (!s1_bright_q)    rgb_d = COLOR_W'(BLACK);
    else if (any_opaque) rgb_d = sel_color;
    else                 rgb_d = s1_bg_q;
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      vsync_prev_q <= SYNC_IDLE;
      shadow_en_q  <= '1;
      shadow_bg_q  <= KEY_COLOR;
      acc_q        <= '0;
      count_q      <= '0;
      flag_q       <= 1'b0;
      done_q       <= 1'b0;
      s1_rgb_q     <= '0;
      s1_opaque_q  <= '0;
      s1_bg_q      <= '0;
      s1_hsync_q   <= SYNC_IDLE;
      s1_vsync_q   <= SYNC_IDLE;
      s1_bright_q  <= 1'b0;
      rgb_q        <= '0;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      bright_q     <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      shadow_en_q  <= shadow_en_d;
      shadow_bg_q  <= shadow_bg_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      flag_q       <= flag_d;
      done_q       <= done_d;
      s1_rgb_q     <= s1_rgb_d;
      s1_opaque_q  <= s1_opaque_d;
      s1_bg_q      <= s1_bg_d;
      s1_hsync_q   <= s1_hsync_d;
      s1_vsync_q   <= s1_vsync_d;
      s1_bright_q  <= s1_bright_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      bright_q     <= bright_d;
    end
  end

  assign rgb_out         = rgb_q;
  assign hSync_out       = hsync_q;
  assign vSync_out       = vsync_q;
  assign bright_out      = bright_q;
  assign collision_count = count_q;
  assign collision_flag  = flag_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: a default-width instance and a 4-bit
// counter instance share the same stimulus.
module tb_layer_compositor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] layerRgb = '0;
  logic [3:0]  layerEn = 4'hF;
  logic [11:0] bgColor = 12'h000;
  logic        hSyncIn = 1'b1;
  logic        vSyncIn = 1'b1;
  logic        brightIn = 1'b0;

  logic        hSyncOut, vSyncOut, brightOut, collisionFlag, frameDone;
  logic [11:0] rgbOut;
  logic [18:0] collisionCount;

  logic        smHSyncOut, smVSyncOut, smBrightOut, smCollisionFlag, smFrameDone;
  logic [11:0] smRgbOut;
  logic [3:0]  smCollisionCount;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  layer_compositor dut (
    .ClkPort         (clock),
    .Reset           (reset),
    .layer_rgb       (layerRgb),
    .layer_en        (layerEn),
    .bg_color        (bgColor),
    .hSync_in        (hSyncIn),
    .vSync_in        (vSyncIn),
    .bright_in       (brightIn),
    .hSync_out       (hSyncOut),
    .vSync_out       (vSyncOut),
    .bright_out      (brightOut),
    .rgb_out         (rgbOut),
    .collision_count (collisionCount),
    .collision_flag  (collisionFlag),
    .frame_done      (frameDone)
  );

  layer_compositor #(.CNT_W(4)) dutSmall (
    .ClkPort         (clock),
    .Reset           (reset),
    .layer_rgb       (layerRgb),
    .layer_en        (layerEn),
    .bg_color        (bgColor),
    .hSync_in        (hSyncIn),
    .vSync_in        (vSyncIn),
    .bright_in       (brightIn),
    .hSync_out       (smHSyncOut),
    .vSync_out       (smVSyncOut),
    .bright_out      (smBrightOut),
    .rgb_out         (smRgbOut),
    .collision_count (smCollisionCount),
    .collision_flag  (smCollisionFlag),
    .frame_done      (smFrameDone)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [11:0] l3, input logic [11:0] l2,
                               input logic [11:0] l1, input logic [11:0] l0,
                               input logic hs, input logic br);
    layerRgb = {l3, l2, l1, l0};
    hSyncIn  = hs;
    brightIn = br;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Assert vSync for one edge (the frame-start edge) with blanking active.
  task automatic frameStart();
    vSyncIn  = 1'b0;
    brightIn = 1'b0;
    tick(1);
  endtask

  task automatic endVsync();
    vSyncIn = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(2);
    checkOutput("reset_rgb",    32'(rgbOut), 32'h000);
    checkOutput("reset_count",  32'(collisionCount), 32'd0);
    checkOutput("reset_flag",   32'(collisionFlag), 32'd0);
    checkOutput("reset_done",   32'(frameDone), 32'd0);
    checkOutput("reset_hsync",  32'(hSyncOut), 32'd1);
    checkOutput("reset_vsync",  32'(vSyncOut), 32'd1);
    checkOutput("reset_bright", 32'(brightOut), 32'd0);
    reset = 1'b0;
    tick(1);

    // Priority: layer 3 is key, layer 2 wins; two overlapping pixels counted.
    applyStimulus(12'hFFF, 12'h0F0, 12'hF00, 12'h00F, 1'b0, 1'b1);
    tick(1);
    checkOutput("latency_rgb_not_yet",   32'(rgbOut), 32'h000);
    checkOutput("latency_hsync_not_yet", 32'(hSyncOut), 32'd1);
    tick(1);
    checkOutput("priority_rgb",  32'(rgbOut), 32'h0F0);
    checkOutput("priority_hsync", 32'(hSyncOut), 32'd0);
    checkOutput("priority_bright", 32'(brightOut), 32'd1);
    applyStimulus(12'hFFF, 12'h0F0, 12'hF00, 12'h00F, 1'b1, 1'b0);
    tick(2);
    checkOutput("blank_rgb", 32'(rgbOut), 32'h000);

    bgColor = 12'h123;
    frameStart();
    checkOutput("frame1_done",  32'(frameDone), 32'd1);
    checkOutput("frame1_count", 32'(collisionCount), 32'd2);
    checkOutput("frame1_flag",  32'(collisionFlag), 32'd1);
    checkOutput("vsync_not_yet", 32'(vSyncOut), 32'd1);
    endVsync();
    checkOutput("vsync_delayed", 32'(vSyncOut), 32'd0);
    checkOutput("done_one_cycle", 32'(frameDone), 32'd0);

    // All layers transparent: shadowed background shows, blanked gives black.
    applyStimulus(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b1);
    tick(2);
    checkOutput("bg_rgb", 32'(rgbOut), 32'h123);
    bgColor = 12'h456;
    tick(2);
    checkOutput("bg_shadowed", 32'(rgbOut), 32'h123);
    brightIn = 1'b0;
    tick(2);
    checkOutput("bg_blank", 32'(rgbOut), 32'h000);

    // Shadowing: disabling layer 3 mid-frame takes effect only at frame start.
    applyStimulus(12'hF0F, 12'h0F0, 12'hFFF, 12'hFFF, 1'b1, 1'b1);
    tick(2);
    checkOutput("shadow_before", 32'(rgbOut), 32'hF0F);
    layerEn = 4'b0111;
    tick(2);
    checkOutput("shadow_midframe", 32'(rgbOut), 32'hF0F);
    frameStart();
    checkOutput("frame2_count", 32'(collisionCount), 32'd4);
    checkOutput("frame2_small_count", 32'(smCollisionCount), 32'd4);
    endVsync();
    brightIn = 1'b1;
    tick(2);
    checkOutput("shadow_after", 32'(rgbOut), 32'h0F0);
    checkOutput("bg_new_shadow_ignored_when_opaque", 32'(rgbOut), 32'h0F0);

    // Frame with no overlap publishes zero.
    layerEn = 4'hF;
    frameStart();
    checkOutput("frame3_count", 32'(collisionCount), 32'd0);
    checkOutput("frame3_flag",  32'(collisionFlag), 32'd0);
    checkOutput("frame3_done",  32'(frameDone), 32'd1);
    endVsync();

    // Collision: 100 pixels with layers 1 and 2 opaque.
    applyStimulus(12'hFFF, 12'h0F0, 12'hF00, 12'hFFF, 1'b1, 1'b1);
    tick(100);
    frameStart();
    checkOutput("collide_count", 32'(collisionCount), 32'd100);
    checkOutput("collide_flag",  32'(collisionFlag), 32'd1);
    checkOutput("collide_done",  32'(frameDone), 32'd1);
    checkOutput("collide_small_sat", 32'(smCollisionCount), 32'd15);
    endVsync();
    checkOutput("collide_done_cleared", 32'(frameDone), 32'd0);

    brightIn = 1'b1;
    tick(20);
    frameStart();
    checkOutput("sat20_count", 32'(collisionCount), 32'd20);
    checkOutput("sat20_small", 32'(smCollisionCount), 32'd15);
    checkOutput("sat20_small_flag", 32'(smCollisionFlag), 32'd1);
    endVsync();

    // Asynchronous reset mid-line, away from any clock edge.
    applyStimulus(12'hFFF, 12'h0F0, 12'hF00, 12'hFFF, 1'b0, 1'b1);
    tick(3);
    checkOutput("pre_reset_rgb", 32'(rgbOut), 32'h0F0);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_rgb",    32'(rgbOut), 32'h000);
    checkOutput("async_hsync",  32'(hSyncOut), 32'd1);
    checkOutput("async_bright", 32'(brightOut), 32'd0);
    checkOutput("async_count",  32'(collisionCount), 32'd0);
    checkOutput("async_flag",   32'(collisionFlag), 32'd0);
    tick(1);
    reset = 1'b0;
    applyStimulus(12'hFFF, 12'h0F0, 12'hF00, 12'hFFF, 1'b1, 1'b0);
    tick(1);
    frameStart();
    checkOutput("post_reset_count", 32'(collisionCount), 32'd0);
    checkOutput("post_reset_flag",  32'(collisionFlag), 32'd0);
    checkOutput("post_reset_done",  32'(frameDone), 32'd1);
    endVsync();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
